// File: rtl/axis_stream_sink.sv
// axis_stream_sink
// AXI-Stream slave that terminates the AES-256-CTR ciphertext stream.
// It accepts beats under a fixed or LFSR-driven backpressure pattern,
// watches the sender for stability violations, counts words and frames,
// and folds every frame into a rotate-XOR checksum.
//
// Handshake: a beat transfers on a rising edge where s_axis_tvalid and
// s_axis_tready are both high. Once the sender raises tvalid it must hold
// tvalid, tdata and tlast unchanged until that transfer happens. tready is
// a register and never depends combinationally on tvalid.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   s_axis_tdata   stream data (DATA_WIDTH)
//   s_axis_tvalid  stream valid
//   s_axis_tlast   end of frame
//   s_axis_tready  registered ready
//   word_count     accepted beats since reset (32, wraps)
//   frame_count    completed frames since reset (16, wraps)
//   frame_checksum checksum of the last completed frame (DATA_WIDTH)
//   frame_done     one-cycle pulse when frame_checksum updates
//   err            sticky error flag
//   err_code       first error: 0 none, 1 valid dropped,
//                  2 data/last changed while stalled, 3 overlength
//   state_dbg      FSM state: 0 IDLE, 1 ACTIVE, 2 HALT
module axis_stream_sink #(
   parameter int          DATA_WIDTH  = 128,
   parameter int          READY_MODE  = 0,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   parameter int          MAX_BEATS   = 4096,
   parameter int          HALT_ON_ERR = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [31:0]           word_count,
   output logic [15:0]           frame_count,
   output logic [DATA_WIDTH-1:0] frame_checksum,
   output logic                  frame_done,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [1:0]            state_dbg
);

   // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HALT   = 2'd2
   } state_t;

   state_t                state;
   logic [15:0]           lfsr;
   logic [DATA_WIDTH-1:0] acc;
   logic [31:0]           beat_cnt;

   // Bus history from the previous edge for the stability monitor.
   logic                  prev_valid;
   logic                  prev_ready;
   logic                  prev_last;
   logic [DATA_WIDTH-1:0] prev_data;

   logic                  accept;
   logic                  stalled;
   logic                  viol_drop;
   logic                  viol_change;
   logic                  viol_over;
   logic                  err_now;
   logic [1:0]            code_now;
   logic                  halt_next;
   logic                  ready_next;
   logic [15:0]           lfsr_next;
   logic [DATA_WIDTH-1:0] acc_next;

   always_comb begin
      accept      = s_axis_tvalid & s_axis_tready;
      stalled     = prev_valid & ~prev_ready;
      viol_drop   = stalled & ~s_axis_tvalid;
      viol_change = stalled & s_axis_tvalid &
                    ((s_axis_tdata != prev_data) | (s_axis_tlast != prev_last));
      // beat_cnt holds beats already accepted in this frame, so this is
      // beat number beat_cnt+1 arriving without tlast.
      viol_over   = accept & ~s_axis_tlast & (beat_cnt >= 32'(MAX_BEATS));
      err_now     = viol_drop | viol_change | viol_over;

      code_now = 2'd0;
      if (viol_drop)        code_now = 2'd1;
      else if (viol_change) code_now = 2'd2;
      else if (viol_over)   code_now = 2'd3;

      halt_next = (state == HALT) | (err_now & (HALT_ON_ERR != 0));

      if (halt_next)            ready_next = 1'b0;
      else if (READY_MODE != 0) ready_next = lfsr[0] | lfsr[1];
      else                      ready_next = 1'b1;

      lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
      acc_next  = {acc[DATA_WIDTH-2:0], acc[DATA_WIDTH-1]} ^ s_axis_tdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         lfsr           <= SEED;
         acc            <= '0;
         beat_cnt       <= '0;
         prev_valid     <= 1'b0;
         prev_ready     <= 1'b0;
         prev_last      <= 1'b0;
         prev_data      <= '0;
         s_axis_tready  <= 1'b0;
         word_count     <= '0;
         frame_count    <= '0;
         frame_checksum <= '0;
         frame_done     <= 1'b0;
         err            <= 1'b0;
         err_code       <= 2'd0;
      end else begin
         lfsr          <= lfsr_next;
         s_axis_tready <= ready_next;
         frame_done    <= 1'b0;

         prev_valid <= s_axis_tvalid;
         prev_ready <= s_axis_tready;
         prev_last  <= s_axis_tlast;
         prev_data  <= s_axis_tdata;

         // Only the first error is kept.
         if (err_now && !err) begin
            err      <= 1'b1;
            err_code <= code_now;
         end

         if (accept) begin
            word_count <= word_count + 32'd1;
            if (s_axis_tlast) begin
               frame_checksum <= acc_next;
               frame_done     <= 1'b1;
               frame_count    <= frame_count + 16'd1;
               acc            <= '0;
               beat_cnt       <= '0;
            end else begin
               acc      <= acc_next;
               beat_cnt <= beat_cnt + 32'd1;
            end
         end

         if (halt_next)   state <= HALT;
         else if (accept) state <= s_axis_tlast ? IDLE : ACTIVE;
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_axis_stream_sink.sv
module tb_axis_stream_sink;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: always-ready, MAX_BEATS=4, halts on error.
   logic        a_rst = 1'b0;
   logic [31:0] a_data = '0;
   logic        a_valid = 1'b0;
   logic        a_last = 1'b0;
   logic        a_ready;
   logic [31:0] a_wc;
   logic [15:0] a_fc;
   logic [31:0] a_cks;
   logic        a_done;
   logic        a_err;
   logic [1:0]  a_code;
   logic [1:0]  a_state;

   // Instance B: LFSR backpressure, keeps running after errors.
   logic        b_rst = 1'b0;
   logic [31:0] b_data = '0;
   logic        b_valid = 1'b0;
   logic        b_last = 1'b0;
   logic        b_ready;
   logic [31:0] b_wc;
   logic [15:0] b_fc;
   logic [31:0] b_cks;
   logic        b_done;
   logic        b_err;
   logic [1:0]  b_code;
   logic [1:0]  b_state;

   axis_stream_sink #(.DATA_WIDTH(32), .READY_MODE(0), .MAX_BEATS(4), .HALT_ON_ERR(1)) dut_a (
      .clk(clk), .rst(a_rst), .s_axis_tdata(a_data), .s_axis_tvalid(a_valid),
      .s_axis_tlast(a_last), .s_axis_tready(a_ready), .word_count(a_wc),
      .frame_count(a_fc), .frame_checksum(a_cks), .frame_done(a_done),
      .err(a_err), .err_code(a_code), .state_dbg(a_state));

   axis_stream_sink #(.DATA_WIDTH(32), .READY_MODE(1), .HALT_ON_ERR(0)) dut_b (
      .clk(clk), .rst(b_rst), .s_axis_tdata(b_data), .s_axis_tvalid(b_valid),
      .s_axis_tlast(b_last), .s_axis_tready(b_ready), .word_count(b_wc),
      .frame_count(b_fc), .frame_checksum(b_cks), .frame_done(b_done),
      .err(b_err), .err_code(b_code), .state_dbg(b_state));

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks for A ----------------
   task automatic a_reset();
      a_rst = 1'b0; a_valid = 1'b0; a_last = 1'b0; a_data = '0;
      repeat (2) tick();
      chk("a_rst_ready", {31'd0, a_ready}, 32'd0);
      chk("a_rst_wc", a_wc, 32'd0);
      chk("a_rst_fc", {16'd0, a_fc}, 32'd0);
      chk("a_rst_cks", a_cks, 32'd0);
      chk("a_rst_done", {31'd0, a_done}, 32'd0);
      chk("a_rst_err", {31'd0, a_err}, 32'd0);
      chk("a_rst_code", {30'd0, a_code}, 32'd0);
      chk("a_rst_state", {30'd0, a_state}, 32'd0);
   endtask

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        exp_done;
      logic [31:0] exp_cks;
      logic [31:0] exp_wc;
      logic [15:0] exp_fc;
      logic [1:0]  exp_state;
   } vec_t;

   vec_t vec[10];

   // ---------------- reference model for B ----------------
   // Checksum of a frame: start at 0, for each beat rotate left by one and
   // XOR the beat in.
   logic [31:0] b_frame_q[$];
   logic [31:0] exp_q[$];
   int          b_exp_wc = 0;
   int          b_exp_fc = 0;
   int          b_cyc = 0;
   int          b_low = 0;

   task automatic b_step();
      logic        acc;
      logic        exp_done;
      logic [31:0] sum;
      acc = b_valid & b_ready;
      tick();
      exp_done = 1'b0;
      if (acc) begin
         b_exp_wc++;
         b_frame_q.push_back(b_data);
         if (b_last) begin
            sum = '0;
            foreach (b_frame_q[i]) sum = {sum[30:0], sum[31]} ^ b_frame_q[i];
            exp_q.push_back(sum);
            b_frame_q.delete();
            b_exp_fc++;
            exp_done = 1'b1;
         end
         b_valid = 1'b0;
      end
      chk("b_done", {31'd0, b_done}, {31'd0, exp_done});
      chk("b_wc", b_wc, b_exp_wc);
      if (exp_done) begin
         chk("b_cks", b_cks, exp_q.pop_front());
         chk("b_fc", {16'd0, b_fc}, b_exp_fc & 32'hFFFF);
      end
      b_cyc++;
      if (!b_ready) b_low++;
   endtask

   task automatic b_offer(input int last_pct);
      if (!b_valid && $urandom_range(0, 3) != 0) begin
         b_valid = 1'b1;
         b_data  = $urandom;
         b_last  = ($urandom_range(0, 99) < last_pct);
      end
   endtask

   // ---------------- test ----------------
   initial begin
      bit found;

      vec[0] = '{32'h0000_0001, 1'b0, 1'b0, 32'h0,         32'd1,  16'd0, 2'd1};
      vec[1] = '{32'h0000_0002, 1'b0, 1'b0, 32'h0,         32'd2,  16'd0, 2'd1};
      vec[2] = '{32'h0000_0003, 1'b1, 1'b1, 32'h3,         32'd3,  16'd1, 2'd0};
      vec[3] = '{32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEADBEEF,  32'd4,  16'd2, 2'd0};
      vec[4] = '{32'h8000_0001, 1'b0, 1'b0, 32'hDEADBEEF,  32'd5,  16'd2, 2'd1};
      vec[5] = '{32'h0000_0010, 1'b1, 1'b1, 32'h13,        32'd6,  16'd3, 2'd0};
      vec[6] = '{32'h0000_0001, 1'b0, 1'b0, 32'h13,        32'd7,  16'd3, 2'd1};
      vec[7] = '{32'h0000_0001, 1'b0, 1'b0, 32'h13,        32'd8,  16'd3, 2'd1};
      vec[8] = '{32'h0000_0001, 1'b0, 1'b0, 32'h13,        32'd9,  16'd3, 2'd1};
      vec[9] = '{32'h0000_0001, 1'b1, 1'b1, 32'hF,         32'd10, 16'd4, 2'd0};

      // A1: tvalid dropped during the post-reset stall cycle.
      a_reset();
      a_rst = 1'b1; a_valid = 1'b1; a_data = 32'h55;
      tick();
      chk("a1_ready_up", {31'd0, a_ready}, 32'd1);
      chk("a1_no_false_err", {31'd0, a_err}, 32'd0);
      a_valid = 1'b0;
      tick();
      chk("a1_err", {31'd0, a_err}, 32'd1);
      chk("a1_code", {30'd0, a_code}, 32'd1);
      chk("a1_ready_low", {31'd0, a_ready}, 32'd0);
      chk("a1_state_halt", {30'd0, a_state}, 32'd2);
      a_valid = 1'b1; a_data = 32'h66;
      tick();
      a_data = 32'h77; a_last = 1'b1;
      tick();
      a_valid = 1'b0; a_last = 1'b0;
      tick();
      chk("a1_code_kept", {30'd0, a_code}, 32'd1);
      chk("a1_ready_stays_low", {31'd0, a_ready}, 32'd0);
      chk("a1_wc", a_wc, 32'd0);

      // A2: table of frames at full rate.
      a_reset();
      a_rst = 1'b1;
      tick();
      chk("a2_ready_first", {31'd0, a_ready}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         a_valid = 1'b1; a_data = vec[i].data; a_last = vec[i].last;
         tick();
         chk($sformatf("v%0d_done", i), {31'd0, a_done}, {31'd0, vec[i].exp_done});
         chk($sformatf("v%0d_cks", i), a_cks, vec[i].exp_cks);
         chk($sformatf("v%0d_wc", i), a_wc, vec[i].exp_wc);
         chk($sformatf("v%0d_fc", i), {16'd0, a_fc}, {16'd0, vec[i].exp_fc});
         chk($sformatf("v%0d_state", i), {30'd0, a_state}, {30'd0, vec[i].exp_state});
         chk($sformatf("v%0d_err", i), {31'd0, a_err}, 32'd0);
      end
      a_valid = 1'b0; a_last = 1'b0;
      tick();
      chk("a2_done_one_cycle", {31'd0, a_done}, 32'd0);

      // A3: five beats without tlast against MAX_BEATS=4.
      for (int i = 0; i < 5; i++) begin
         a_valid = 1'b1; a_data = 32'h100 + i; a_last = 1'b0;
         tick();
         if (i < 4) chk($sformatf("a3_err_beat%0d", i + 1), {31'd0, a_err}, 32'd0);
      end
      chk("a3_err", {31'd0, a_err}, 32'd1);
      chk("a3_code", {30'd0, a_code}, 32'd3);
      chk("a3_ready_low", {31'd0, a_ready}, 32'd0);
      chk("a3_wc", a_wc, 32'd15);
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      chk("a3_code_kept", {30'd0, a_code}, 32'd3);

      // A4: reset mid-frame, then a clean 2-beat frame.
      a_reset();
      a_rst = 1'b1;
      tick();
      a_valid = 1'b1; a_data = 32'hA; a_last = 1'b0;
      tick();
      a_data = 32'hB; a_last = 1'b1;
      tick();
      a_valid = 1'b0; a_last = 1'b0;
      chk("a4_done", {31'd0, a_done}, 32'd1);
      chk("a4_cks", a_cks, 32'h1F);
      chk("a4_wc", a_wc, 32'd2);
      chk("a4_fc", {16'd0, a_fc}, 32'd1);
      chk("a4_err", {31'd0, a_err}, 32'd0);

      // B1: 100 random single-beat frames under LFSR backpressure.
      b_rst = 1'b0;
      repeat (2) tick();
      b_rst = 1'b1;
      b_cyc = 0; b_low = 0;
      for (int c = 0; c < 3000 && b_exp_fc < 100; c++) begin
         b_offer(100);
         b_step();
      end
      chk("b1_fc", {16'd0, b_fc}, 32'd100);
      chk("b1_wc", b_wc, 32'd100);
      chk("b1_err", {31'd0, b_err}, 32'd0);
      chk("b1_duty", {31'd0, (b_low * 100 >= b_cyc * 12) && (b_low * 100 <= b_cyc * 38)}, 32'd1);

      // B2: change tdata while stalled; sink keeps running.
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         if (!b_valid) begin
            b_valid = 1'b1; b_data = $urandom; b_last = 1'b1;
         end
         if (!b_ready) found = 1'b1;
         else b_step();
      end
      chk("b2_stall_found", {31'd0, found}, 32'd1);
      if (found) begin
         b_step();
         chk("b2_no_err_yet", {31'd0, b_err}, 32'd0);
         b_data = b_data ^ 32'h1;
         b_step();
         chk("b2_err", {31'd0, b_err}, 32'd1);
         chk("b2_code", {30'd0, b_code}, 32'd2);
      end

      // B3: random multi-beat frames after the error.
      for (int c = 0; c < 600; c++) begin
         b_offer(25);
         b_step();
      end
      chk("b3_frames_progress", {31'd0, b_exp_fc > 110}, 32'd1);
      chk("b3_code_kept", {30'd0, b_code}, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_stream_sink.md
# axis_stream_sink

AXI-Stream slave terminating the ciphertext output of the AES-256-CTR core in simulation and on-board self-test builds; counterpart of the plaintext producer on the input side. Accepts beats under a configurable backpressure pattern, checks the sender against AXI-Stream stability rules, counts words and frames, and produces a per-frame rotate-XOR checksum for comparison against the software reference model. Fully synthesizable; no file I/O.

## Interface
Parameters:
- DATA_WIDTH, 128, tdata width in bits (≥ 2).
- READY_MODE, 0, 0 = tready held high; 1 = LFSR-driven backpressure.
- LFSR_SEED, 16'hACE1, initial LFSR state; 0 is replaced by 16'h0001.
- MAX_BEATS, 4096, maximum beats per frame before an overlength error.
- HALT_ON_ERR, 1, 1 = deassert tready permanently after the first error.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  end of frame.
- s_axis_tready  out  1  registered ready.
- word_count  out  32  accepted beats since reset (wraps at 2^32).
- frame_count  out  16  completed frames since reset (wraps at 2^16).
- frame_checksum  out  DATA_WIDTH  checksum of last completed frame.
- frame_done  out  1  one-cycle pulse when frame_checksum updates.
- err  out  1  sticky error flag.
- err_code  out  2  first error seen: 0 none, 1 valid dropped, 2 data/last changed while stalled, 3 overlength.

## Operation
- Beat accepted when s_axis_tvalid && s_axis_tready at a rising edge.
- States: IDLE (no frame open), ACTIVE (≥1 beat of current frame accepted), HALT (error with HALT_ON_ERR=1).
- IDLE→ACTIVE on accepted beat with tlast=0; accepted beat with tlast=1 in IDLE is a one-beat frame, stays IDLE.
- ACTIVE→IDLE on accepted beat with tlast=1.
- Any state→HALT on error when HALT_ON_ERR=1; HALT exits only via reset. With HALT_ON_ERR=0, errors are flagged and operation continues.
- Checksum: running acc (DATA_WIDTH bits, 0 at frame start); per accepted beat acc_next = {acc[W-2:0], acc[W-1]} ^ tdata. On the tlast beat, frame_checksum <= acc_next, acc <= 0, frame_done pulses, frame_count increments.
- Beat counter per frame; accepting beat number MAX_BEATS+1 without tlast raises err_code 3; counter resets to 0 with the frame (no saturation needed beyond that point; error already sticky).
- Protocol monitor: registers previous tvalid, tready, tdata, tlast. If previous cycle had tvalid=1, tready=0: current tvalid=0 → code 1; tdata or tlast differ → code 2. Code 1 has priority over 2 in same cycle.
- err/err_code record only the first error; later errors do not overwrite.
- Backpressure: 16-bit Galois LFSR, mask 16'hB400, shifts every cycle out of reset. READY_MODE=1: tready_next = lfsr[0] | lfsr[1] (≈75% duty). READY_MODE=0: tready_next = 1. HALT forces tready_next = 0.

## Timing
- Reset (rst=0 at edge): tready=0, word_count=0, frame_count=0, frame_checksum=0, frame_done=0, err=0, err_code=0, state IDLE, acc=0, LFSR=seed, monitor history cleared (no false error on first cycle after reset).
- tready first high in cycle 1 after rst deasserts (READY_MODE=0); registered, never combinationally dependent on tvalid.
- frame_done and frame_checksum valid in the cycle after the tlast beat is accepted; one cycle wide.
- word_count updates the cycle after each accepted beat.
- err asserts the cycle after the violating edge; tready low from the same cycle when HALT_ON_ERR=1.
- Reset mid-frame discards partial acc and beat count; no frame_done.
- Back-to-back frames (tlast then next beat next cycle) supported at full rate.

## Test plan
- READY_MODE=0, 3-beat frame 0x1,0x2,0x3 (tlast on third) → frame_checksum 0x3 ^ (0x2^(0x1<<1))<<1 = 0x3, frame_done one pulse, word_count 3, frame_count 1, err 0.
- One-beat frame tdata=0xDEADBEEF with tlast → frame_checksum 0xDEADBEEF, state stays IDLE, frame_count 1.
- READY_MODE=1, 100 single-beat frames, compliant producer → frame_count 100, word_count 100, tready low on ~25% of cycles, err 0.
- Producer drops tvalid during stall → err 1, err_code 1, tready 0 thereafter (HALT_ON_ERR=1); later violations leave err_code 1.
- Producer changes tdata during stall with HALT_ON_ERR=0 → err_code 2, subsequent frames still counted and checksummed.
- MAX_BEATS=4, 5 beats without tlast → err_code 3 on fifth beat; reset mid-frame then clean 2-beat frame → counters 2/1, err 0.
